// File: rtl/pixel_writeback.sv
// pixel_writeback
//   Captures filtered pixels from the invert filter stage (px_valid = filter
//   ap_done), buffers them in a small FIFO and writes them, packed {R,G,B},
//   sequentially into an output BRAM under out_ready back-pressure. After
//   NUM_PIXELS pixels have been written a one-cycle frame_done pulse is
//   produced. Dropped or excess pixels raise the sticky overflow flag.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      frame start, sampled only when idle
//   px_valid   filtered pixel present on px_r/px_g/px_b this cycle
//   px_r/g/b   filtered colour components
//   out_ready  BRAM/arbiter can accept a write this cycle
//   out_we     BRAM write enable (combinational)
//   out_addr   BRAM write address
//   out_din    packed pixel {r,g,b} at the FIFO head
//   busy       frame in progress (RUN or DRAIN)
//   frame_done one-cycle pulse after the last pixel is written
//   overflow   sticky dropped/excess-pixel flag, cleared by reset or start
//   px_count   pixels accepted in the current frame
module pixel_writeback #(
    parameter int unsigned NUM_PIXELS = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              px_valid,
    input  logic [7:0]        px_r,
    input  logic [7:0]        px_g,
    input  logic [7:0]        px_b,
    input  logic              out_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [23:0]       out_din,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W:0]   px_count
);

    localparam int unsigned     PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [23:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   fill, fill_nxt;
    logic [ADDR_W:0]  acc_cnt, wr_cnt, wr_cnt_nxt;
    logic             in_frame, fifo_empty, fifo_full;
    logic             push, pop, ovf_nxt;

    assign in_frame   = (state == RUN) || (state == DRAIN);
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL);

    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign pop  = in_frame && !fifo_empty && out_ready;
    assign push = (state == RUN) && px_valid && (!fifo_full || pop);

    assign wr_cnt_nxt = wr_cnt + {{ADDR_W{1'b0}}, pop};

    always_comb begin
        fill_nxt = fill;
        if (push && !pop) begin
            fill_nxt = fill + 1'b1;
        end else if (pop && !push) begin
            fill_nxt = fill - 1'b1;
        end
    end

    // A new start clears the flag; any pixel not pushed (idle, full FIFO,
    // drain, done) sets it.
    always_comb begin
        ovf_nxt = overflow;
        if ((state == IDLE) && start) begin
            ovf_nxt = 1'b0;
        end else if (px_valid && !push) begin
            ovf_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (push && (acc_cnt == LAST - 1'b1)) state_nxt = DRAIN;
            // Completion is judged on post-write values so frame_done follows
            // the last write by exactly one cycle.
            DRAIN: if ((wr_cnt_nxt == LAST) && (fill_nxt == '0)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= ovf_nxt;
            if ((state == IDLE) && start) begin
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (push) acc_cnt <= acc_cnt + 1'b1;
                wr_cnt <= wr_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            fill <= fill_nxt;
            if (push) begin
                mem[wr_ptr] <= {px_r, px_g, px_b};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign out_we     = pop;
    assign out_din    = mem[rd_ptr];
    assign out_addr   = wr_cnt[ADDR_W-1:0];
    assign busy       = in_frame;
    assign frame_done = (state == DONE);
    assign px_count   = acc_cnt;

endmodule

// File: tb/tb_pixel_writeback.sv
// tb_pixel_writeback
//   Drives pixel_writeback with directed frames (nominal, back-pressure,
//   overrun, push/pop on a full FIFO, early/excess pixels, mid-frame reset)
//   followed by randomized traffic, and compares every output each cycle
//   against a queue-based frame model.
module tb_pixel_writeback;

    localparam int unsigned N      = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, px_valid, out_ready;
    logic [7:0]        px_r, px_g, px_b;
    logic              out_we, busy, frame_done, overflow;
    logic [ADDR_W-1:0] out_addr;
    logic [23:0]       out_din;
    logic [ADDR_W:0]   px_count;

    int checks   = 0;
    int failures = 0;

    // Frame model: a frame is either active or not; pixels live in a queue.
    bit          active;
    bit          done_pulse;
    bit          ovf;
    int          acc;
    int          wr;
    logic [23:0] q[$];

    pixel_writeback #(
        .NUM_PIXELS(N),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .px_valid  (px_valid),
        .px_r      (px_r),
        .px_g      (px_g),
        .px_b      (px_b),
        .out_ready (out_ready),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_din   (out_din),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow),
        .px_count  (px_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        active     = 1'b0;
        done_pulse = 1'b0;
        ovf        = 1'b0;
        acc        = 0;
        wr         = 0;
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},       out_we,     0);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_done"},     frame_done, 0);
        check({tag, "_overflow"}, overflow,   0);
        check({tag, "_count"},    px_count,   0);
        check({tag, "_addr"},     out_addr,   0);
        check({tag, "_din"},      out_din,    0);
    endtask

    // One clock cycle: drive, compare before the edge, advance the model.
    task automatic step(input bit st, input bit v, input logic [23:0] pix, input bit rdy);
        bit exp_we, was_full, draining;
        @(negedge clk);
        #1;
        start     = st;
        px_valid  = v;
        {px_r, px_g, px_b} = pix;
        out_ready = rdy;
        #2;
        exp_we = active && (q.size() > 0) && rdy;
        check("busy",       busy,       active);
        check("out_we",     out_we,     exp_we);
        check("frame_done", frame_done, done_pulse);
        check("overflow",   overflow,   ovf);
        check("px_count",   px_count,   acc);
        if (exp_we) begin
            check("out_addr", out_addr, wr % (1 << ADDR_W));
            check("out_din",  out_din,  q[0]);
        end
        @(posedge clk);
        if (done_pulse) begin
            done_pulse = 1'b0;
            if (v) ovf = 1'b1;
        end else if (!active) begin
            if (st) begin
                active = 1'b1;
                acc    = 0;
                wr     = 0;
                ovf    = 1'b0;
            end else if (v) begin
                ovf = 1'b1;
            end
        end else begin
            was_full = (q.size() == DEPTH);
            draining = (acc == N);
            if (exp_we) begin
                void'(q.pop_front());
                wr++;
            end
            if (v) begin
                if (!draining && (!was_full || exp_we)) begin
                    q.push_back(pix);
                    acc++;
                end else begin
                    ovf = 1'b1;
                end
            end
            if (draining && (wr == N)) begin
                active     = 1'b0;
                done_pulse = 1'b1;
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset();
        @(negedge clk);
        start    = 1'b0;
        px_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [23:0] seq_pix(input int i);
        logic [7:0] r, g, b;
        r = 8'(8'h10 + i);
        g = 8'(8'h20 + i);
        b = 8'(8'h30 + i);
        return {r, g, b};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        px_valid = 1'b0;
        out_ready = 1'b0;
        px_r = '0;
        px_g = '0;
        px_b = '0;
        model_reset();
        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Nominal frame, one pixel per cycle.
        step(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < int'(N); i++) step(1'b0, 1'b1, seq_pix(i), 1'b1);
        idle_cycles(4);

        // Back-pressure: fill the FIFO while stalled, then release.
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 32), 1'b0);
        step(1'b0, 1'b0, 24'h0, 1'b0);
        step(1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < int'(N - DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 48), 1'b1);
        idle_cycles(8);

        // Overrun: one pixel more than the FIFO holds while stalled.
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i <= int'(DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 64), 1'b0);
        for (int i = 0; i < int'(N - DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 80), 1'b1);
        idle_cycles(8);

        // Full FIFO with push and pop in the same cycle.
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 96), 1'b0);
        for (int i = 0; i < int'(N - DEPTH); i++) step(1'b0, 1'b1, seq_pix(i + 112), 1'b1);
        idle_cycles(8);

        // Early pixel while idle, then an excess pixel during drain.
        step(1'b0, 1'b1, 24'hABCDEF, 1'b1);
        step(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < int'(N); i++) step(1'b0, 1'b1, seq_pix(i + 128), 1'b1);
        step(1'b0, 1'b1, 24'h123456, 1'b1);
        idle_cycles(4);

        // Reset after two writes, then a clean frame from address 0.
        step(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, seq_pix(i + 144), 1'b1);
        mid_reset();
        idle_cycles(2);
        step(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < int'(N); i++) step(1'b0, 1'b1, seq_pix(i + 160), 1'b1);
        idle_cycles(4);

        // Randomized traffic with varying back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
            end else begin
                step($urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) < 6,
                     24'($urandom),
                     $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 8 : 4));
            end
        end
        idle_cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_writeback.md
Name: pixel_writeback

Overview:
- Sits directly downstream of the invert filter stage.
- Captures each filtered pixel (newRed/newGreen/newBlue) when the filter signals ap_done, and buffers it in a small FIFO.
- Packs the pixel as {R,G,B} and writes it sequentially into an output BRAM, with back-pressure from the memory side.
- Counts one frame of NUM_PIXELS pixels, then pulses frame completion; also flags dropped or excess pixels.

Parameters:
- NUM_PIXELS, 256, pixels per frame; must be >= 1 and <= 2**ADDR_W.
- ADDR_W, 8, output BRAM address width.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame start; sampled only in IDLE.
- px_valid  in  1  filter ap_done; px_r/px_g/px_b are valid this cycle.
- px_r  in  8  filtered red.
- px_g  in  8  filtered green.
- px_b  in  8  filtered blue.
- out_ready  in  1  output BRAM/arbiter can take a write this cycle.
- out_we  out  1  output BRAM write enable.
- out_addr  out  ADDR_W  output BRAM write address.
- out_din  out  24  packed pixel {px_r, px_g, px_b}.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse when the last pixel has been written.
- overflow  out  1  sticky error flag; cleared by reset or by a new start.
- px_count  out  ADDR_W+1  pixels accepted this frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; FIFO empty.
  - Internal counters acc_cnt=0 and wr_cnt=0.
  - busy=0, frame_done=0, overflow=0, px_count=0, out_addr=0.
  - out_we=0, out_din=0.
  - Reset asserted mid-frame aborts the frame with no frame_done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; acc_cnt, wr_cnt and overflow are cleared.
  - px_valid in IDLE is ignored and sets overflow.
- RUN, accept:
  - px_valid=1 and (FIFO not full, or FIFO full with a pop in the same cycle) -> push {px_r,px_g,px_b} and increment acc_cnt.
  - px_valid=1 with FIFO full and no pop -> pixel dropped, overflow set, acc_cnt unchanged.
  - The edge at which acc_cnt reaches NUM_PIXELS moves the state to DRAIN.
- Write (RUN or DRAIN):
  - out_we is combinational: out_we = FIFO non-empty AND out_ready.
  - out_din = FIFO head; out_addr = wr_cnt[ADDR_W-1:0].
  - On out_we the FIFO pops and wr_cnt increments.
  - out_we is never asserted in IDLE or DONE; out_din holds the head value otherwise (don't-care when the FIFO is empty).
- DRAIN:
  - px_valid is ignored and sets overflow.
  - FIFO empty and wr_cnt==NUM_PIXELS -> DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored (no restart, no flag).
- Latency: a pixel captured at edge N can appear on out_we no earlier than the cycle after edge N. With out_ready held at 1, throughput is 1 pixel/cycle.
- Widths:
  - acc_cnt and wr_cnt are ADDR_W+1 bits wide, so the value NUM_PIXELS is representable.
  - out_addr wraps naturally in the address field; it never exceeds NUM_PIXELS-1 within a frame.
- px_count = acc_cnt.
- busy = (state==RUN || state==DRAIN).
- Ordering: pixels are written in capture order; no reordering and no duplication.

Test Plan:
1. Nominal frame with NUM_PIXELS=4:
   - Stimulus: reset, start pulse, out_ready=1, then px_valid on 4 consecutive cycles with R/G/B = (0x10,0x20,0x30), (0x11,0x21,0x31), …
   - Required: out_we on 4 consecutive cycles, addr 0..3, out_din 0x102030, 0x112131, …; frame_done one cycle after the last write; overflow=0; px_count=4.
2. Back-pressure:
   - Stimulus: out_ready=0 while 4 pixels arrive with FIFO_DEPTH=4, then out_ready=1.
   - Required: no out_we while stalled; then 4 writes in order; overflow=0.
3. FIFO overrun:
   - Stimulus: out_ready=0 and 5 back-to-back px_valid.
   - Required: 5th pixel dropped; overflow=1 and stays 1; px_count=4.
4. Simultaneous push/pop on full FIFO:
   - Stimulus: FIFO full, out_ready=1 and px_valid=1 in the same cycle.
   - Required: pixel accepted, no overflow, count stays consistent.
5. Extra and early pixels:
   - Stimulus: px_valid while in IDLE, and a 5th px_valid during DRAIN.
   - Required: both ignored; overflow=1; exactly NUM_PIXELS writes.
6. Reset mid-frame:
   - Stimulus: assert reset after 2 writes.
   - Required: out_we=0 and all outputs 0 immediately (asynchronous), no frame_done.
   - Then a new start re-runs the frame from addr 0.
